// File: rtl/queue_fifo_hs_if.sv
// queue_fifo_hs_if
// Handshake bundle for queue_fifo_hs.
//   Write side: wr_valid_in and wr_data_in go from the producer to the FIFO.
//               wr_ready_out goes from the FIFO to the producer.
//   Read side:  rd_valid_out and rd_data_out go from the FIFO to the consumer.
//               rd_ready_in goes from the consumer to the FIFO.
// Handshake rule, both sides: a transfer happens on a rising clock edge
// only when valid and ready are both high in that cycle. Valid never
// depends on ready. Ready never depends on valid. The data sent with
// valid stays stable until the transfer completes.
// modports: master = producer/consumer, slave = the FIFO.
interface queue_fifo_hs_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  wr_valid_in;
  logic [DATA_WIDTH-1:0] wr_data_in;
  logic                  wr_ready_out;
  logic                  rd_valid_out;
  logic [DATA_WIDTH-1:0] rd_data_out;
  logic                  rd_ready_in;

  modport master (
    output wr_valid_in, wr_data_in, rd_ready_in,
    input  wr_ready_out, rd_valid_out, rd_data_out
  );

  modport slave (
    input  wr_valid_in, wr_data_in, rd_ready_in,
    output wr_ready_out, rd_valid_out, rd_data_out
  );
endinterface

// File: rtl/queue_fifo_hs.sv
// queue_fifo_hs
// Circular-buffer FIFO with first-word-fall-through output. It has
// valid/ready handshakes on the write side and on the read side.
// Ports:
//   clk_in           clock; all logic runs on the rising edge
//   rst_n_in         synchronous active-low reset
//   flush_in         synchronous clear of pointers, count and overflow
//   hs               handshake bundle (slave modport)
//   count_out        number of stored words, 0..DEPTH
//   almost_full_out  high when count >= ALMOST_FULL
//   almost_empty_out high when count <= ALMOST_EMPTY
//   overflow_out     sticky; set after a write attempt while full
// DEPTH must be a power of two and at least 2, so the pointers wrap
// without any extra logic.
module queue_fifo_hs #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int ALMOST_FULL  = DEPTH - 2,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   flush_in,
  queue_fifo_hs_if.slave         hs,
  output logic [$clog2(DEPTH):0] count_out,
  output logic                   almost_full_out,
  output logic                   almost_empty_out,
  output logic                   overflow_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wp;
  logic [AW-1:0]         rp;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  // Full and empty come from the count register only. The pointers are
  // equal in both states, so pointer equality cannot tell them apart.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Ready is based on the registered count. A pop in the same cycle
  // therefore does not let a write into a full FIFO.
  assign push = hs.wr_valid_in && !full;
  assign pop  = hs.rd_ready_in && !empty;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush_in) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (hs.wr_valid_in && full) overflow <= 1'b1;
    end
  end

  // Storage is never reset. Only the pointers decide which words are live.
  always_ff @(posedge clk_in) begin
    if (rst_n_in && !flush_in && push) mem[wp] <= hs.wr_data_in;
  end

  assign hs.wr_ready_out  = !full;
  assign hs.rd_valid_out  = !empty;
  assign hs.rd_data_out   = mem[rp];
  assign count_out        = count;
  assign almost_full_out  = (count >= CW'(ALMOST_FULL));
  assign almost_empty_out = (count <= CW'(ALMOST_EMPTY));
  assign overflow_out     = overflow;
endmodule
